// File: rtl/burst_ram_pkg.sv
// Shared types and widths for the burst RAM: FSM state encoding and beat/mask widths.
package burst_ram_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = 8;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        READ_WAIT,
        READ,
        WRITE
    } state_e;

endpackage

// File: rtl/burst_ram_mem.sv
// Single-port 2^ADDR_W x 64 storage with byte write enables and a one-cycle registered read.
module burst_ram_mem
    import burst_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [MASK_W-1:0] be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned WORDS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;

    // No reset on the array or read register so the block maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(MASK_W); b++) begin
                if (be[b]) begin
                    mem_q[addr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/burst_ram.sv
// Burst RAM controller: init delay, fixed-latency read bursts and streamed write bursts.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int unsigned DEPTH_BITWIDTH           = 12,
    parameter int unsigned BURST_BEATS              = 4,
    parameter int unsigned CYCLES_BEFORE_DATA_VALID = 8,   // minimum 4
    parameter int unsigned CYCLES_BEFORE_INITIATED  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd,
    input  logic                      cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [MASK_W-1:0]         data_mask,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_data_valid,
    output logic                      busy,
    output logic                      init_calib
);

    localparam int unsigned CNT_MAX = (CYCLES_BEFORE_INITIATED > CYCLES_BEFORE_DATA_VALID) ?
                                      CYCLES_BEFORE_INITIATED : CYCLES_BEFORE_DATA_VALID;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BEAT_W  = $clog2(BURST_BEATS + 1);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [BEAT_W-1:0]         iss_q, iss_d;
    logic [DEPTH_BITWIDTH-1:0] addr_q, addr_d;
    logic                      pend_q, pend_d;
    logic                      busy_q, busy_d;
    logic                      init_calib_q, init_calib_d;
    logic                      rd_data_valid_q, rd_data_valid_d;
    logic [DATA_W-1:0]         rd_data_q, rd_data_d;

    logic                      mem_we_c;
    logic                      mem_we;
    logic [MASK_W-1:0]         mem_be;
    logic [DEPTH_BITWIDTH-1:0] mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= INIT;
            cnt_q           <= '0;
            beat_q          <= '0;
            iss_q           <= '0;
            addr_q          <= '0;
            pend_q          <= 1'b0;
            busy_q          <= 1'b1;
            init_calib_q    <= 1'b0;
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            beat_q          <= beat_d;
            iss_q           <= iss_d;
            addr_q          <= addr_d;
            pend_q          <= pend_d;
            busy_q          <= busy_d;
            init_calib_q    <= init_calib_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_data_q       <= rd_data_d;
        end
    end

    // Reads are issued two cycles ahead of the output beat: one cycle in the RAM, one in rd_data_q.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        beat_d          = beat_q;
        iss_d           = iss_q;
        addr_d          = addr_q;
        pend_d          = 1'b0;
        busy_d          = busy_q;
        init_calib_d    = init_calib_q;
        rd_data_valid_d = 1'b0;
        rd_data_d       = rd_data_q;
        mem_we          = 1'b0;
        mem_be          = ~data_mask;
        mem_addr        = addr;
        mem_wdata       = wr_data;

        if (pend_q) begin
            rd_data_valid_d = 1'b1;
            rd_data_d       = mem_rdata;
        end

        case (state_q)
            INIT: begin
                busy_d       = 1'b1;
                init_calib_d = 1'b0;
                if (cnt_q == CNT_W'(CYCLES_BEFORE_INITIATED - 1)) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    busy_d       = 1'b0;
                    init_calib_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                busy_d = 1'b0;
                if (cmd_en && init_calib_q) begin
                    addr_d = addr;
                    if (cmd) begin
                        mem_we = 1'b1;
                        if (BURST_BEATS > 1) begin
                            state_d = WRITE;
                            beat_d  = BEAT_W'(1);
                            busy_d  = 1'b1;
                        end
                    end else begin
                        state_d = READ_WAIT;
                        cnt_d   = CNT_W'(1);
                        beat_d  = '0;
                        iss_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
            end
            READ_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CYCLES_BEFORE_DATA_VALID - 3)) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (iss_q != BEAT_W'(BURST_BEATS)) begin
                    pend_d   = 1'b1;
                    mem_addr = addr_q + DEPTH_BITWIDTH'(iss_q);
                    iss_d    = iss_q + BEAT_W'(1);
                end
                if (rd_data_valid_q) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(BURST_BEATS - 1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            WRITE: begin
                mem_we   = 1'b1;
                mem_addr = addr_q + DEPTH_BITWIDTH'(beat_q);
                beat_d   = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(BURST_BEATS - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // A reset arriving mid-burst must not commit the beat presented on that edge.
    assign mem_we_c = mem_we & rst_n;

    burst_ram_mem #(
        .ADDR_W (DEPTH_BITWIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_c),
        .be    (mem_be),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;
    assign busy          = busy_q;
    assign init_calib    = init_calib_q;

endmodule

// File: tb/tb_burst_ram.sv
// Scoreboard bench for burst_ram: directed write/read bursts with a decoupled beat monitor.
module tb_burst_ram;

    localparam int unsigned AW = 12;

    typedef logic [63:0] beats_t [4];
    typedef logic [7:0]  masks_t [4];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd = 1'b0;
    logic          cmd_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [63:0]   wr_data = '0;
    logic [7:0]    data_mask = '0;
    logic [63:0]   rd_data;
    logic          rd_data_valid;
    logic          busy;
    logic          init_calib;

    int            total = 0;
    int            bad = 0;
    logic [63:0]   exp_q [$];

    burst_ram #(
        .DEPTH_BITWIDTH           (AW),
        .BURST_BEATS              (4),
        .CYCLES_BEFORE_DATA_VALID (8),
        .CYCLES_BEFORE_INITIATED  (10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd           (cmd),
        .cmd_en        (cmd_en),
        .addr          (addr),
        .wr_data       (wr_data),
        .data_mask     (data_mask),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .busy          (busy),
        .init_calib    (init_calib)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic monitor();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rd_data_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %h want no beat", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("read_beat", rd_data, e);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_and_init(input bit inject);
        logic [9:0] ipat;
        logic [9:0] bpat;
        ipat = '0;
        bpat = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (inject && k == 3) begin
                cmd_en = 1'b1; cmd = 1'b1; addr = 12'h300;
                wr_data = 64'hBAD0_BAD0_BAD0_BAD0; data_mask = 8'h00;
            end
            if (k == 4) begin
                cmd_en = 1'b0; cmd = 1'b0; wr_data = '0;
            end
            @(negedge clk);
            ipat[k-1] = init_calib;
            bpat[k-1] = busy;
        end
        check("init_calib_timing", 64'(ipat), 64'h200);
        check("init_busy_timing", 64'(bpat), 64'h1FF);
        check("init_no_valid", 64'(rd_data_valid), 64'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input beats_t d, input masks_t m);
        cmd_en = 1'b1; cmd = 1'b1; addr = a;
        wr_data = d[0]; data_mask = m[0];
        tick();
        cmd_en = 1'b0; cmd = 1'b0;
        for (int i = 1; i < 4; i++) begin
            wr_data = d[i]; data_mask = m[i];
            tick();
        end
        wr_data = '0; data_mask = '0;
        @(negedge clk);
        check("write_busy_release", 64'(busy), 64'd0);
    endtask

    // inj > 0 drives a write cmd_en to 0x010 in that cycle of the read, which must be ignored.
    task automatic do_read(input logic [AW-1:0] a, input beats_t e, input int inj);
        logic [11:0] vpat;
        logic [11:0] bpat;
        vpat = '0;
        bpat = '0;
        for (int i = 0; i < 4; i++) exp_q.push_back(e[i]);
        cmd_en = 1'b1; cmd = 1'b0; addr = a;
        tick();
        cmd_en = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            vpat[c-1] = rd_data_valid;
            bpat[c-1] = busy;
            if (c == inj) begin
                cmd_en = 1'b1; cmd = 1'b1; addr = 12'h010;
                wr_data = 64'h0BAD_0BAD_0BAD_0BAD; data_mask = 8'h00;
            end
            if (c < 12) begin
                tick();
                if (c == inj) begin
                    cmd_en = 1'b0; cmd = 1'b0; wr_data = '0;
                end
            end
        end
        check("read_valid_window", 64'(vpat), 64'h780);
        check("read_busy_window", 64'(bpat), 64'h7FF);
    endtask

    initial begin
        beats_t b_a, b_seq, b_m1, b_m0, b_mexp, b_wrap, b_two;
        masks_t m_zero, m_hi;
        logic [8:0] vpat;

        b_a    = '{64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002,
                   64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0004};
        b_seq  = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        b_m1   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hA5A5_A5A5_A5A5_A5A5,
                   64'h5A5A_5A5A_5A5A_5A5A, 64'hC3C3_C3C3_C3C3_C3C3};
        b_m0   = '{64'h0, 64'h0, 64'h0, 64'h0};
        b_mexp = '{64'hFFFF_FFFF_0000_0000, 64'hA5A5_A5A5_A5A5_A5A5,
                   64'h5A5A_5A5A_5A5A_5A5A, 64'hC3C3_C3C3_C3C3_C3C3};
        b_wrap = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   64'hDEAD_BEEF_CAFE_F00D, 64'h0F0F_F0F0_0F0F_F0F0};
        b_two  = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h0, 64'h0};
        m_zero = '{8'h00, 8'h00, 8'h00, 8'h00};
        m_hi   = '{8'hF0, 8'hFF, 8'hFF, 8'hFF};

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_init_calib", 64'(init_calib), 64'd0);
        check("reset_busy", 64'(busy), 64'd1);
        check("reset_valid", 64'(rd_data_valid), 64'd0);
        check("reset_rd_data", rd_data, 64'd0);

        release_and_init(1'b1);
        check("rd_data_zero_before_read", rd_data, 64'd0);

        do_write(12'h300, b_a, m_zero);
        do_write(12'h010, b_seq, m_zero);
        do_read(12'h010, b_seq, 0);

        do_write(12'h020, b_m1, m_zero);
        do_write(12'h020, b_m0, m_hi);
        do_read(12'h020, b_mexp, 0);
        check("rd_data_holds_last", rd_data, 64'hC3C3_C3C3_C3C3_C3C3);

        do_write(12'hFFE, b_wrap, m_zero);
        do_read(12'hFFE, b_wrap, 0);

        do_read(12'h010, b_seq, 3);
        do_read(12'h010, b_seq, 0);

        // Reset lands right after the second valid beat of this read.
        exp_q.push_back(b_two[0]);
        exp_q.push_back(b_two[1]);
        vpat = '0;
        cmd_en = 1'b1; cmd = 1'b0; addr = 12'h010;
        tick();
        cmd_en = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            vpat[c-1] = rd_data_valid;
            if (c < 9) tick();
        end
        rst_n = 1'b0;
        check("midread_valid_window", 64'(vpat), 64'h180);
        tick();
        @(negedge clk);
        check("midread_reset_valid", 64'(rd_data_valid), 64'd0);
        check("midread_reset_rd_data", rd_data, 64'd0);
        check("midread_reset_busy", 64'(busy), 64'd1);
        check("midread_reset_init", 64'(init_calib), 64'd0);
        repeat (2) @(negedge clk);
        check("reset_hold_valid", 64'(rd_data_valid), 64'd0);

        release_and_init(1'b1);
        do_read(12'h300, b_a, 0);
        do_read(12'h010, b_seq, 0);
        do_read(12'hFFE, b_wrap, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
